step_grid_ctrl: RTL and testbench

Cursor and step-state controller for the 12×12 step-sequencer grid, directly upstream of the VGA display stage. It turns button presses into cursor moves and step toggles and keeps the 144-bit step pattern. For every move it presents the new and old cell pixel origins plus the old cell's step bit, issues a one-cycle draw request, then tracks the display's `drawing` signal until the redraw is complete.

---
 rtl/step_grid_if.sv | 23 ++
 rtl/step_grid_ctrl.sv | 161 ++++++++++++++++
 tb/tb_step_grid_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/step_grid_if.sv
// Button/display bundle between the step-grid controller (master) and the
// button pads plus VGA display stage (slave).
interface step_grid_if;
  logic         btn_left, btn_right, btn_up, btn_down, btn_toggle;
  logic         drawing;
  logic [9:0]   X, OLD_X;
  logic [8:0]   Y, OLD_Y;
  logic         state;
  logic         draw_enable;
  logic         ready;
  logic [143:0] steps;
  logic [3:0]   cur_col, cur_row;

  modport master (
    input  btn_left, btn_right, btn_up, btn_down, btn_toggle, drawing,
    output X, Y, OLD_X, OLD_Y, state, draw_enable, ready, steps, cur_col, cur_row
  );

  modport slave (
    output btn_left, btn_right, btn_up, btn_down, btn_toggle, drawing,
    input  X, Y, OLD_X, OLD_Y, state, draw_enable, ready, steps, cur_col, cur_row
  );
endinterface

// File: rtl/step_grid_ctrl.sv
// Cursor / step-pattern controller for the 12x12 sequencer grid feeding the VGA stage.
// Define STEP_GRID_WRAP_EN to make cursor moves wrap at the grid edges (default: saturate).

module step_btn_cond (
  input  logic CLOCK_50,
  input  logic nReset,
  input  logic btn,
  output logic evt
);
  // [0],[1] synchronize; [2] holds the previous synced level for edge detection
  logic [2:0] vld_pipe;

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      vld_pipe <= '0;
      evt      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], btn};
      evt      <= vld_pipe[1] & ~vld_pipe[2];
    end
  end
endmodule

module step_grid_ctrl #(
  parameter logic [9:0] X0    = 10'd214,
  parameter logic [8:0] Y0    = 9'd32,
  parameter int         PITCH = 33
) (
  input  logic         CLOCK_50,
  input  logic         nReset,
  step_grid_if.master  bus
);
  localparam int NUM_BTN = 5;
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_TOG = 4;

  typedef enum logic [1:0] {INIT_WAIT, IDLE, ISSUE, BUSY} fsm_t;

  logic [NUM_BTN-1:0] btn_raw, evt;
  fsm_t               fsm;
  logic               drawing_q, seen_rise;
  logic [1:0]         ep_cnt, ep_tgt;
  logic [3:0]         nxt_col, nxt_row;
  logic [7:0]         cur_idx;
  logic               do_move;
  logic               draw_rise, draw_fall;

  assign btn_raw = {bus.btn_toggle, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  step_btn_cond u_btn [NUM_BTN-1:0] (
    .CLOCK_50 (CLOCK_50),
    .nReset   (nReset),
    .btn      (btn_raw),
    .evt      (evt)
  );

  function automatic logic [9:0] cell_x(input logic [3:0] c);
    return X0 + 10'(c) * 10'(PITCH);
  endfunction

  function automatic logic [8:0] cell_y(input logic [3:0] r);
    return Y0 + 9'(r) * 9'(PITCH);
  endfunction

`ifdef STEP_GRID_WRAP_EN
  function automatic logic [3:0] step_inc(input logic [3:0] v);
    return (v == 4'd11) ? 4'd0 : v + 4'd1;
  endfunction
  function automatic logic [3:0] step_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd11 : v - 4'd1;
  endfunction
`else
  function automatic logic [3:0] step_inc(input logic [3:0] v);
    return (v == 4'd11) ? v : v + 4'd1;
  endfunction
  function automatic logic [3:0] step_dec(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction
`endif

  assign cur_idx   = 8'(bus.cur_row) * 8'd12 + 8'(bus.cur_col);
  assign draw_rise = bus.drawing & ~drawing_q;
  assign draw_fall = ~bus.drawing & drawing_q;

  // Only the highest-priority event is considered; toggle masks all moves
  always_comb begin
    nxt_col = bus.cur_col;
    nxt_row = bus.cur_row;
    if (!evt[B_TOG]) begin
      if (evt[B_RIGHT])      nxt_col = step_inc(bus.cur_col);
      else if (evt[B_LEFT])  nxt_col = step_dec(bus.cur_col);
      else if (evt[B_DOWN])  nxt_row = step_inc(bus.cur_row);
      else if (evt[B_UP])    nxt_row = step_dec(bus.cur_row);
    end
    do_move = !evt[B_TOG] && ((nxt_col != bus.cur_col) || (nxt_row != bus.cur_row));
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      fsm             <= INIT_WAIT;
      drawing_q       <= 1'b0;
      seen_rise       <= 1'b0;
      ep_cnt          <= '0;
      ep_tgt          <= '0;
      bus.X           <= X0;
      bus.Y           <= Y0;
      bus.OLD_X       <= X0;
      bus.OLD_Y       <= Y0;
      bus.state       <= 1'b0;
      bus.draw_enable <= 1'b0;
      bus.ready       <= 1'b0;
      bus.steps       <= '0;
      bus.cur_col     <= '0;
      bus.cur_row     <= '0;
    end else begin
      drawing_q <= bus.drawing;
      case (fsm)
        // The display's power-on grid + cursor draw is one rise/fall episode
        INIT_WAIT: begin
          if (draw_rise) seen_rise <= 1'b1;
          if (seen_rise && draw_fall) begin
            fsm       <= IDLE;
            bus.ready <= 1'b1;
          end
        end
        IDLE: begin
          if (evt[B_TOG]) begin
            bus.steps[cur_idx] <= ~bus.steps[cur_idx];
          end else if (do_move) begin
            bus.OLD_X   <= bus.X;
            bus.OLD_Y   <= bus.Y;
            bus.state   <= bus.steps[cur_idx];
            bus.cur_col <= nxt_col;
            bus.cur_row <= nxt_row;
            bus.X       <= cell_x(nxt_col);
            bus.Y       <= cell_y(nxt_row);
            bus.ready   <= 1'b0;
            fsm         <= ISSUE;
          end
        end
        // Any fall seen here predates our request, so the count starts clean
        ISSUE: begin
          bus.draw_enable <= 1'b1;
          ep_cnt          <= '0;
          ep_tgt          <= 2'd2;
          fsm             <= BUSY;
        end
        BUSY: begin
          bus.draw_enable <= 1'b0;
          if (draw_fall) begin
            ep_cnt <= ep_cnt + 2'd1;
            if (ep_cnt + 2'd1 == ep_tgt) begin
              fsm       <= IDLE;
              bus.ready <= 1'b1;
            end
          end
        end
        default: fsm <= INIT_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_step_grid_ctrl.sv
// Directed, table-driven bench for step_grid_ctrl; a stand-in display answers each
// draw request with two busy bursts separated by a one-cycle gap.
module tb_step_grid_ctrl;
  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #10 clk = ~clk;

  step_grid_if bus();

  step_grid_ctrl dut (
    .CLOCK_50 (clk),
    .nReset   (nReset),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  // mask bit order: {toggle, right, left, down, up}
  localparam logic [4:0] MR = 5'b01000, ML = 5'b00100, MD = 5'b00010,
                         MU = 5'b00001, MT = 5'b10000;

  typedef struct {
    logic [4:0] mask;
    int draw;
    int col, row, x, y, ox, oy, st;
    int flip;
  } vec_t;

  logic [143:0] exp_steps = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_steps(input string nm);
    checks++;
    if (bus.steps !== exp_steps) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, bus.steps, exp_steps);
    end
  endtask

  task automatic set_btn(input logic [4:0] m);
    {bus.btn_toggle, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = m;
  endtask

  // Press buttons (entered at posedge+1), play the display, report timing.
  // de_at: edge index of draw_enable; rdy_at: edges from draw to ready rise.
  task automatic serve(input logic [4:0] mask, input logic [4:0] busy_mask, input bit pre_fall,
                       output int de_at, output int rdy_at, output int n_de,
                       output bit rdy_dropped, output bit unstable);
    int start, t;
    logic [9:0] x0; logic [8:0] y0; logic [9:0] ox0; logic [8:0] oy0; logic s0;
    start = -1; de_at = -1; rdy_at = -1; n_de = 0; rdy_dropped = 0; unstable = 0;
    x0 = '0; y0 = '0; ox0 = '0; oy0 = '0; s0 = 0;
    set_btn(mask);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (bus.draw_enable) begin
        n_de++;
        if (start < 0) begin
          start = i; de_at = i;
          x0 = bus.X; y0 = bus.Y; ox0 = bus.OLD_X; oy0 = bus.OLD_Y; s0 = bus.state;
        end
      end
      if (start < 0 && !bus.ready) rdy_dropped = 1;
      if (start >= 0 && rdy_at < 0 &&
          (bus.X !== x0 || bus.Y !== y0 || bus.OLD_X !== ox0 || bus.OLD_Y !== oy0 || bus.state !== s0))
        unstable = 1;
      if (start >= 0 && i > start && rdy_at < 0 && bus.ready) rdy_at = i - start;
      if (i == 4) set_btn(5'b0);
      if (start >= 0) begin
        t = i - start;
        if (t == 2) set_btn(busy_mask);
        if (t == 5) set_btn(5'b0);
        bus.drawing = (t >= 1 && t <= 3) || (t >= 5 && t <= 7);
      end else begin
        bus.drawing = pre_fall && (i <= 3);
      end
    end
    bus.drawing = 1'b0;
    set_btn(5'b0);
  endtask

  task automatic chk_pos(input string nm, input int col, input int row, input int x, input int y,
                         input int ox, input int oy, input int st);
    chk({nm, ".col"},   bus.cur_col, col);
    chk({nm, ".row"},   bus.cur_row, row);
    chk({nm, ".X"},     bus.X, x);
    chk({nm, ".Y"},     bus.Y, y);
    chk({nm, ".OLD_X"}, bus.OLD_X, ox);
    chk({nm, ".OLD_Y"}, bus.OLD_Y, oy);
    chk({nm, ".state"}, bus.state, st);
  endtask

  task automatic chk_draw(input string nm, input int de_at, input int rdy_at, input int n_de,
                          input bit unstable);
    chk({nm, ".n_draw"}, n_de, 1);
    chk({nm, ".de_at"},  de_at, 5);
    chk({nm, ".rdy_at"}, rdy_at, 9);
    chk({nm, ".stable"}, unstable, 0);
  endtask

  task automatic do_init();
    // a toggle while still waiting for the display must be dropped
    set_btn(MT);
    repeat (4) @(posedge clk); #1;
    set_btn(5'b0);
    repeat (6) @(posedge clk); #1;
    chk("init.ready_pre", bus.ready, 0);
    chk_steps("init.steps_toggle_dropped");
    bus.drawing = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("init.ready_busy", bus.ready, 0);
    chk("init.X_busy", bus.X, 214);
    bus.drawing = 1'b0;
    @(posedge clk); #1;
    chk("init.ready_post", bus.ready, 1);
    chk("init.X", bus.X, 214);
    chk("init.Y", bus.Y, 32);
    chk("init.draw_enable", bus.draw_enable, 0);
  endtask

  initial begin
    vec_t vt[9];
    int de_at, rdy_at, n_de;
    bit rdy_dropped, unstable;

    vt[0] = '{MR,      1, 1, 0, 247, 32, 214, 32, 0, -1};
    vt[1] = '{ML,      1, 0, 0, 214, 32, 247, 32, 0, -1};
    vt[2] = '{MT,      0, 0, 0, 214, 32, 247, 32, 0,  0};
    vt[3] = '{MD,      1, 0, 1, 214, 65, 214, 32, 1, -1};
    vt[4] = '{ML | MT, 0, 0, 1, 214, 65, 214, 32, 1, 12};
    vt[5] = '{MU,      1, 0, 0, 214, 32, 214, 65, 1, -1};
    vt[6] = '{MR | ML | MD, 1, 1, 0, 247, 32, 214, 32, 1, -1};
    vt[7] = '{MD | MU, 1, 1, 1, 247, 65, 247, 32, 0, -1};
    vt[8] = '{MT,      0, 1, 1, 247, 65, 247, 32, 0, 13};

    set_btn(5'b0);
    bus.drawing = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_pos("reset", 0, 0, 214, 32, 214, 32, 0);
    chk("reset.ready", bus.ready, 0);
    chk("reset.draw_enable", bus.draw_enable, 0);
    chk_steps("reset.steps");
    nReset = 1'b1;
    do_init();

    for (int k = 0; k < 9; k++) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      serve(vt[k].mask, 5'b0, 1'b0, de_at, rdy_at, n_de, rdy_dropped, unstable);
      if (vt[k].flip >= 0) exp_steps[vt[k].flip] = ~exp_steps[vt[k].flip];
      if (vt[k].draw != 0) begin
        chk_draw(nm, de_at, rdy_at, n_de, unstable);
      end else begin
        chk({nm, ".n_draw"}, n_de, 0);
        chk({nm, ".ready_held"}, rdy_dropped, 0);
      end
      chk_pos(nm, vt[k].col, vt[k].row, vt[k].x, vt[k].y, vt[k].ox, vt[k].oy, vt[k].st);
      chk_steps({nm, ".steps"});
    end

    // up pressed while BUSY is dropped: one draw only, row stays 1
    serve(MR, MU, 1'b0, de_at, rdy_at, n_de, rdy_dropped, unstable);
    chk_draw("busy_drop", de_at, rdy_at, n_de, unstable);
    chk_pos("busy_drop", 2, 1, 280, 65, 247, 65, 1);
    chk("busy_drop.ready", bus.ready, 1);

    // a drawing fall landing in ISSUE must not count toward the episode
    serve(ML, 5'b0, 1'b1, de_at, rdy_at, n_de, rdy_dropped, unstable);
    chk_draw("issue_fall", de_at, rdy_at, n_de, unstable);
    chk_pos("issue_fall", 1, 1, 247, 65, 280, 65, 0);

    for (int k = 0; k < 10; k++)
      serve(MR, 5'b0, 1'b0, de_at, rdy_at, n_de, rdy_dropped, unstable);
    chk_pos("to_col11", 11, 1, 577, 65, 544, 65, 0);

    serve(MR, 5'b0, 1'b0, de_at, rdy_at, n_de, rdy_dropped, unstable);
`ifdef STEP_GRID_WRAP_EN
    chk_draw("edge_right", de_at, rdy_at, n_de, unstable);
    chk_pos("edge_right", 0, 1, 214, 65, 577, 65, 0);
`else
    chk("edge_right.n_draw", n_de, 0);
    chk("edge_right.ready_held", rdy_dropped, 0);
    chk_pos("edge_right", 11, 1, 577, 65, 544, 65, 0);
`endif

    // reset in the middle of BUSY
    set_btn(ML);
    n_de = 0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (bus.draw_enable) n_de++;
      if (i == 4) set_btn(5'b0);
    end
    chk("midreset.draw_seen", n_de, 1);
    #1 nReset = 1'b0;
    #1;
    exp_steps = '0;
    chk_pos("midreset", 0, 0, 214, 32, 214, 32, 0);
    chk("midreset.ready", bus.ready, 0);
    chk("midreset.draw_enable", bus.draw_enable, 0);
    chk_steps("midreset.steps");
    @(posedge clk); #1;
    nReset = 1'b1;
    do_init();

    serve(MR, 5'b0, 1'b0, de_at, rdy_at, n_de, rdy_dropped, unstable);
    chk_draw("post_reset", de_at, rdy_at, n_de, unstable);
    chk_pos("post_reset", 1, 0, 247, 32, 214, 32, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
